// File: rtl/imem_server.sv
// imem_server: instruction memory for the fetch stage.
// A loader streams a little-endian byte image: a 4-byte word count, then the
// words themselves. The words are packed and written into a word RAM. Fetch
// reads have a fixed 1-cycle latency and no handshake.
// Optional build macro IMEM_CHECKSUM_EN adds a running 32-bit word sum of the
// image. Without it, checksum is tied to zero.
module imem_server #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imemraddr,
  output logic [31:0] imemrdata,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  output logic        loaded,
  output logic        overflow,
  output logic        addr_err,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {ST_LEN, ST_DATA, ST_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_buf;
  logic [31:0] r_len;
  logic [31:0] r_word_cnt;
  logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];

  logic        w_accept;
  logic        w_last_byte;
  logic        w_word_done;
  logic        w_wr_en;
  logic        w_rd_in_range;
  logic [31:0] w_word;

  // The fourth byte of a group goes straight into the top lane, so a
  // completed word is available on the same edge that accepts that byte.
  assign w_word        = {load_data, r_buf};
  assign w_last_byte   = (r_byte_cnt == 2'd3);
  assign w_rd_in_range = (imemraddr[31:ADDR_WIDTH+2] == '0);
  assign loaded        = (r_state == ST_DONE);

  // Next-state logic and the handshake and write-strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    w_accept    = 1'b0;
    w_word_done = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      ST_LEN: begin
        load_ready = 1'b1;
        w_accept   = load_valid;
        if (load_valid && w_last_byte)
          w_state_nxt = (w_word == 32'd0) ? ST_DONE : ST_DATA;
      end
      ST_DATA: begin
        load_ready = 1'b1;
        w_accept   = load_valid;
        if (load_valid && w_last_byte) begin
          w_word_done = 1'b1;
          w_wr_en     = (r_word_cnt[31:ADDR_WIDTH] == '0);
          if (r_word_cnt + 32'd1 == r_len)
            w_state_nxt = ST_DONE;
        end
      end
      default: ;
    endcase
  end

  // Control state: FSM, counters, header length and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_LEN;
      r_byte_cnt <= 2'd0;
      r_word_cnt <= 32'd0;
      r_len      <= 32'd0;
      overflow   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)
        r_byte_cnt <= r_byte_cnt + 2'd1;
      if (r_state == ST_LEN && w_accept && w_last_byte)
        r_len <= w_word;
      if (w_word_done) begin
        r_word_cnt <= r_word_cnt + 32'd1;
        if (!w_wr_en)
          overflow <= 1'b1;
      end
      if (loaded && imemraddr[1:0] != 2'b00)
        addr_err <= 1'b1;
    end
  end

  // Holds the first three bytes of the group being assembled.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      case (r_byte_cnt)
        2'd0:    r_buf[7:0]   <= load_data;
        2'd1:    r_buf[15:8]  <= load_data;
        2'd2:    r_buf[23:16] <= load_data;
        default: ;
      endcase
    end
  end

  // RAM write port; its contents are deliberately kept across reset.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_word_cnt[ADDR_WIDTH-1:0]] <= w_word;
  end

  // Registered read port. It reads before the write on the same edge, so a
  // same-word collision returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      imemrdata <= 32'd0;
    else if (w_rd_in_range)
      imemrdata <= r_mem[imemraddr[ADDR_WIDTH+1:2]];
    else
      imemrdata <= NOP_WORD;
  end

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Adds every word accepted in the data phase, including words dropped on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_checksum <= 32'd0;
    else if (w_word_done)
      r_checksum <= r_checksum + w_word;
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_server.sv
// Bench for imem_server: table-driven load, hand-written corner sequences,
// randomized images against a byte-offset reference model, and a small
// ADDR_WIDTH=2 instance for the overflow case.
module tb_imem_server;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] raddr = 32'd0;
  logic [31:0] rdata;
  logic        lv = 1'b0;
  logic [7:0]  ld = 8'd0;
  logic        lr, ldd, ovf, aerr;
  logic [31:0] csum;

  logic [31:0] s_raddr = 32'd0;
  logic [31:0] s_rdata;
  logic        s_lv = 1'b0;
  logic [7:0]  s_ld = 8'd0;
  logic        s_lr, s_ldd, s_ovf, s_aerr;
  logic [31:0] s_csum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_server #(.ADDR_WIDTH(14)) u_dut (
    .clk(clk), .rst(rst), .imemraddr(raddr), .imemrdata(rdata),
    .load_valid(lv), .load_data(ld), .load_ready(lr), .loaded(ldd),
    .overflow(ovf), .addr_err(aerr), .checksum(csum)
  );

  imem_server #(.ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .imemraddr(s_raddr), .imemrdata(s_rdata),
    .load_valid(s_lv), .load_data(s_ld), .load_ready(s_lr), .loaded(s_ldd),
    .overflow(s_ovf), .addr_err(s_aerr), .checksum(s_csum)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    lv = 1'b1;
    ld = b;
    tick();
    lv = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic s_send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      s_lv = 1'b1;
      s_ld = w[8*i +: 8];
      tick();
      s_lv = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] cs_exp(input logic [31:0] s);
`ifdef IMEM_CHECKSUM_EN
    return s;
`else
    return 32'd0 & s;
`endif
  endfunction

  typedef struct {
    logic [7:0] b;
    logic       exp_loaded;
    logic       exp_ready;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Table for the 2-word example image.
    tbl[0]  = '{8'h02, 1'b0, 1'b1};
    tbl[1]  = '{8'h00, 1'b0, 1'b1};
    tbl[2]  = '{8'h00, 1'b0, 1'b1};
    tbl[3]  = '{8'h00, 1'b0, 1'b1};
    tbl[4]  = '{8'h13, 1'b0, 1'b1};
    tbl[5]  = '{8'h05, 1'b0, 1'b1};
    tbl[6]  = '{8'h10, 1'b0, 1'b1};
    tbl[7]  = '{8'h00, 1'b0, 1'b1};
    tbl[8]  = '{8'h93, 1'b0, 1'b1};
    tbl[9]  = '{8'h05, 1'b0, 1'b1};
    tbl[10] = '{8'h20, 1'b0, 1'b1};
    tbl[11] = '{8'h00, 1'b1, 1'b0};

    // Reset values, sampled while reset is held.
    rst = 1'b1;
    #12;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_loaded", {31'd0, ldd}, 32'd0);
    chk("rst_overflow", {31'd0, ovf}, 32'd0);
    chk("rst_addr_err", {31'd0, aerr}, 32'd0);
    chk("rst_checksum", csum, 32'd0);
    chk("rst_ready", {31'd0, lr}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven load of the example image.
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].b);
      chk($sformatf("tbl_loaded_%0d", i), {31'd0, ldd}, {31'd0, tbl[i].exp_loaded});
      chk($sformatf("tbl_ready_%0d", i), {31'd0, lr}, {31'd0, tbl[i].exp_ready});
    end
    chk("ex_checksum", csum, cs_exp(32'h0030_0AA6));

    // Reads after load: latency, hold and out-of-range.
    raddr = 32'h4;
    tick();
    chk("rd_word1", rdata, 32'h0020_0593);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rd_hold_%0d", i), rdata, 32'h0020_0593);
    end
    raddr = 32'h0;
    tick();
    chk("rd_word0", rdata, 32'h0010_0513);
    raddr = 32'h8000_0000;
    tick();
    chk("rd_oor", rdata, 32'h0000_0013);
    chk("aerr_clean", {31'd0, aerr}, 32'd0);
    raddr = 32'h6;
    tick();
    chk("rd_misaligned", rdata, 32'h0020_0593);
    chk("aerr_set", {31'd0, aerr}, 32'd1);
    raddr = 32'h0;
    tick();
    chk("aerr_sticky", {31'd0, aerr}, 32'd1);

    // Bytes offered in DONE are ignored.
    send(8'hFF);
    send(8'hEE);
    chk("done_loaded", {31'd0, ldd}, 32'd1);
    chk("done_ready", {31'd0, lr}, 32'd0);
    tick();
    chk("done_ram0", rdata, 32'h0010_0513);

    // Zero-length header.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(8'h00);
      chk($sformatf("zlen_notyet_%0d", i), {31'd0, ldd}, 32'd0);
    end
    send(8'h00);
    chk("zlen_loaded", {31'd0, ldd}, 32'd1);
    chk("zlen_ready", {31'd0, lr}, 32'd0);
    send(8'h12);
    send(8'h34);
    chk("zlen_extra_loaded", {31'd0, ldd}, 32'd1);
    chk("zlen_extra_ovf", {31'd0, ovf}, 32'd0);
    chk("zlen_extra_cs", csum, 32'd0);

    // Reset after 6 data bytes of a 3-word image.
    do_reset();
    send_word(32'd3);
    send_word(32'h5566_7788);
    send(8'hAA);
    send(8'hBB);
    raddr = 32'h2;
    rst = 1'b1;
    #2;
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_loaded", {31'd0, ldd}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("mid_rst_aerr", {31'd0, aerr}, 32'd0);
    chk("mid_rst_cs", csum, 32'd0);
    chk("mid_rst_ready", {31'd0, lr}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    raddr = 32'h0;
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    chk("fresh_loaded", {31'd0, ldd}, 32'd1);
    chk("fresh_cs", csum, cs_exp(32'hDEAD_BEEF));
    tick();
    chk("fresh_ram0", rdata, 32'hDEAD_BEEF);

    // Same-word write/read collision during DATA.
    do_reset();
    send_word(32'd2);
    raddr = 32'h0;
    send(8'h04);
    send(8'h03);
    send(8'h02);
    send(8'h01);
    chk("coll_old", rdata, 32'hDEAD_BEEF);
    tick();
    chk("coll_new", rdata, 32'h0102_0304);
    send_word(32'h0BAD_F00D);
    chk("coll_loaded", {31'd0, ldd}, 32'd1);

    // Randomized images against a byte-offset model.
    for (int r = 0; r < 3; r++) begin
      logic [7:0]  img[$];
      logic [31:0] mram [int];
      logic [31:0] mlen, msum, w, exp_rd, a;
      int          nb, written, pos, cyc, len, k;
      bit          done, v;
      do_reset();
      img.delete();
      mram.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < 4; i++) img.push_back(8'(len >> (8 * i)));
      for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
      nb = 0; written = 0; pos = 0; cyc = 0; done = 0; msum = 0; mlen = 0;
      while (!done && cyc < 2000) begin
        cyc++;
        v = ($urandom_range(0, 2) != 0) && (pos < img.size());
        if (written > 0 && $urandom_range(0, 3) != 0) begin
          a = 32'($urandom_range(0, written - 1)) * 4;
          exp_rd = mram[int'(a >> 2)];
        end else begin
          a = {1'b1, 31'($urandom)} & 32'hFFFF_FFFC;
          exp_rd = 32'h0000_0013;
        end
        raddr = a;
        lv = v;
        ld = v ? img[pos] : 8'h00;
        tick();
        lv = 1'b0;
        if (v) begin
          pos++;
          nb++;
          if (nb == 4) begin
            mlen = {img[3], img[2], img[1], img[0]};
            if (mlen == 0) done = 1;
          end else if (nb > 4 && nb % 4 == 0) begin
            k = (nb - 4) / 4 - 1;
            w = {img[nb-1], img[nb-2], img[nb-3], img[nb-4]};
            mram[k] = w;
            written = k + 1;
            msum += w;
            if (k + 1 == int'(mlen)) done = 1;
          end
        end
        chk($sformatf("rnd%0d_rd_c%0d", r, cyc), rdata, exp_rd);
        chk($sformatf("rnd%0d_loaded_c%0d", r, cyc), {31'd0, ldd}, {31'd0, done});
      end
      chk($sformatf("rnd%0d_finished", r), {31'd0, done}, 32'd1);
      chk($sformatf("rnd%0d_cs", r), csum, cs_exp(msum));
      chk($sformatf("rnd%0d_ovf", r), {31'd0, ovf}, 32'd0);
    end

    // Overflow on a 4-word RAM: a 5-word image.
    do_reset();
    begin
      logic [31:0] ssum;
      ssum = 0;
      s_send_word(32'd5);
      for (int k = 0; k < 5; k++) begin
        s_send_word(32'hA000_0000 + 32'(k));
        ssum += 32'hA000_0000 + 32'(k);
        if (k == 3) begin
          chk("small_ovf_before", {31'd0, s_ovf}, 32'd0);
          chk("small_loaded_before", {31'd0, s_ldd}, 32'd0);
        end
      end
      chk("small_ovf_after", {31'd0, s_ovf}, 32'd1);
      chk("small_loaded", {31'd0, s_ldd}, 32'd1);
      chk("small_cs", s_csum, cs_exp(ssum));
      for (int k = 0; k < 4; k++) begin
        s_raddr = 32'(k) * 4;
        tick();
        chk($sformatf("small_ram%0d", k), s_rdata, 32'hA000_0000 + 32'(k));
      end
      s_raddr = 32'h10;
      tick();
      chk("small_oor", s_rdata, 32'h0000_0013);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_server.md
Name: imem_server

Overview:
- Instruction-memory responder for the fetch stage.
- Accepts a byte-stream program image from the host-side loader (UART receive path), packs the bytes into 32-bit words and writes them into an on-chip word RAM.
- Serves fetch read requests with fixed 1-cycle latency.
- Asserts `loaded` once the image is complete so the core may leave reset/stall.

Parameters:
- ADDR_WIDTH, 14, word-address width; RAM depth = 2**ADDR_WIDTH words.
- NOP_WORD, 32'h00000013, value returned for out-of-range reads.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- imemraddr  input  32  fetch byte address; sampled every cycle
- imemrdata  output  32  instruction word for address sampled on previous edge
- load_valid  input  1  loader byte strobe
- load_data  input  8  loader byte
- load_ready  output  1  block accepts a byte this cycle
- loaded  output  1  image fully written; level, held until reset
- overflow  output  1  sticky: image longer than RAM depth
- addr_err  output  1  sticky: fetch address with imemraddr[1:0] != 0 while loaded
- checksum  output  32  word sum of loaded image (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=LEN, byte_cnt=0, word_cnt=0, len=0, imemrdata=0, loaded=0, overflow=0, addr_err=0, checksum=0. RAM contents not cleared.
- Byte transfer happens on a rising edge with load_valid & load_ready. load_ready = 1 in LEN and DATA, 0 in DONE.
- Byte packing is little-endian: the first byte of each group of 4 is bits [7:0], the fourth is bits [31:24]. byte_cnt is 2 bits and wraps 3→0.
- FSM:
  - LEN: collects 4 bytes into len (32-bit word count).
    - On the 4th byte: if len==0, go to DONE; else go to DATA.
  - DATA: collects 4 bytes into a word.
    - On the 4th byte: if word_cnt < 2**ADDR_WIDTH, write RAM[word_cnt[ADDR_WIDTH-1:0]]; else drop the word and set overflow.
    - word_cnt increments after each word. When word_cnt+1 == len, go to DONE.
  - DONE: loaded=1 from the cycle after the final byte edge. Terminal until reset.
- Write timing: the RAM write is committed on the same edge that accepts the 4th byte.
- Read path:
  - On every edge, imemrdata <= RAM[imemraddr[ADDR_WIDTH+1:2]] if imemraddr[31:ADDR_WIDTH+2]==0; else imemrdata <= NOP_WORD.
  - Latency is exactly 1 cycle, no handshake. Address held constant yields a stable output (fetch stall behaviour).
- Read/write collision on the same word in the same cycle: read-first, so imemrdata shows the old contents. Reads during LEN/DATA are legal and return current RAM contents.
- addr_err is set on an edge where loaded=1 and imemraddr[1:0]!=0. The read still uses bits [ADDR_WIDTH+1:2].
- load_valid in DONE is ignored; no state change.
- Reset mid-load returns to LEN. Words already written remain in RAM; the next image overwrites from word 0.
- Must infer a single-port-write / single-port-read block RAM. No combinational path from imemraddr to imemrdata.

Optional Feature:
- Macro: IMEM_CHECKSUM_EN.
- Defined: checksum += each 32-bit word accepted in DATA, modulo 2**32. Dropped (overflow) words are included. Reset clears it. The host compares it against its own sum.
- Undefined: checksum tied to 0, and the accumulator is not synthesised.

Test Plan:
- Load bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 → RAM[0]=0x00100513, RAM[1]=0x00200593; loaded rises the cycle after the 12th byte. checksum=0x00300AA6 with IMEM_CHECKSUM_EN, else 0.
- After load: imemraddr=0x4 at edge N → imemrdata=0x00200593 after edge N. Address held 3 cycles → output stable. imemraddr=0x8000_0000 → 0x00000013.
- Header 00 00 00 00 → loaded=1 immediately after the 4th byte, load_ready=0 thereafter. Extra load_valid pulses produce no change.
- ADDR_WIDTH=2, len=5, five distinct words → RAM holds words 0-3; overflow=1 after word 4; loaded=1.
- Assert rst after 6 data bytes of a 3-word image → all outputs return to reset values, load_ready=1. A fresh 1-word image loads correctly to RAM[0].
- After load, imemraddr=0x6 → addr_err=1 (sticky), imemrdata=RAM[1]. Write and read of word 0 in the same cycle during DATA → old value returned.
